// File: rtl/csi_packetizer.sv
// csi_packetizer: ping-pong frame buffer between the CSI equalizer output and
// the DMA-facing AXI-Stream master. Each complete N_SC-word frame is emitted as
// {MAGIC, seq} followed by the N_SC stored words. The CSI input is never
// back-pressured; frames with no free bank are dropped and counted, and
// malformed frames are discarded and counted.
module csi_packetizer #(
  parameter int unsigned N_SC  = 64,
  parameter logic [15:0] MAGIC = 16'hC51A
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] drop_count,
  output logic [15:0] err_count
);

  localparam int unsigned      CNT_W    = $clog2(N_SC);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SC - 1);

  typedef enum logic       {WR_FILL, WR_DISCARD}      wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_HDR, RD_DATA} rd_state_t;

  logic [31:0] mem [2][N_SC];
  logic [1:0]  full;
  logic [15:0] seq [2];

  wr_state_t        wr_state;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_bank;
  logic [15:0]      frame_seq;

  rd_state_t        rd_state;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_bank;

  logic             s_beat;
  logic             m_beat;
  logic             free_en;
  logic             wr_full_eff;
  logic             drop_beat;
  logic             store_beat;
  logic             at_end;
  logic             commit;
  logic             other_bank;
  logic [CNT_W-1:0] rd_next;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign s_beat      = s_axis_tvalid && s_axis_tready;
  assign m_beat      = m_axis_tvalid && m_axis_tready;
  // Bank release happens on the handshake of the last data beat.
  assign free_en     = (rd_state == RD_DATA) && m_beat && (rd_cnt == LAST_IDX);
  // A bank freed this cycle is already available to a frame starting this cycle.
  assign wr_full_eff = full[wr_bank] && !(free_en && (rd_bank == wr_bank));
  assign drop_beat   = s_beat && (wr_state == WR_FILL) && (wr_cnt == '0) && wr_full_eff;
  assign store_beat  = s_beat && (wr_state == WR_FILL) && !drop_beat;
  assign at_end      = (wr_cnt == LAST_IDX);
  assign commit      = store_beat && s_axis_tlast && at_end;
  assign other_bank  = ~rd_bank;
  assign rd_next     = rd_cnt + CNT_W'(1);

  // Write FSM: frame framing, drop/error accounting and bank switching.
  // NOTE: state registers use non-blocking assignments so every block sees the
  // previous cycle's values regardless of evaluation order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state      <= WR_FILL;
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      frame_seq     <= '0;
      drop_count    <= '0;
      err_count     <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (s_beat) begin
        unique case (wr_state)
          WR_FILL: begin
            if (drop_beat) begin
              drop_count <= sat_inc(drop_count);
              if (!s_axis_tlast) wr_state <= WR_DISCARD;
            end else if (s_axis_tlast) begin
              wr_cnt <= '0;
              if (at_end) begin
                wr_bank   <= ~wr_bank;
                frame_seq <= frame_seq + 16'd1;
              end else begin
                err_count <= sat_inc(err_count);
              end
            end else if (at_end) begin
              err_count <= sat_inc(err_count);
              wr_cnt    <= '0;
              wr_state  <= WR_DISCARD;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
          WR_DISCARD: begin
            if (s_axis_tlast) begin
              wr_state <= WR_FILL;
              wr_cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

  // Per-bank full flags and sequence tags; set on commit, cleared on free.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      full   <= '0;
      seq[0] <= '0;
      seq[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (free_en && (rd_bank == 1'(b))) full[b] <= 1'b0;
        if (commit && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
          seq[b]  <= frame_seq;
        end
      end
    end
  end

  // Frame storage write port.
  // NOTE: the storage array is deliberately not reset; the full flags alone
  // say whether a bank holds a valid frame.
  always_ff @(posedge aclk) begin
    if (store_beat) mem[wr_bank][wr_cnt] <= s_axis_tdata;
  end

  // Read FSM: output register doubles as the prefetch stage, so the next word
  // is loaded on the handshake and outputs hold steady while stalled.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state      <= RD_IDLE;
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (full[rd_bank]) begin
            m_axis_tdata  <= {MAGIC, seq[rd_bank]};
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            rd_state      <= RD_HDR;
          end
        end
        RD_HDR: begin
          if (m_axis_tready) begin
            m_axis_tdata <= mem[rd_bank][0];
            rd_cnt       <= '0;
            rd_state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axis_tready) begin
            if (rd_cnt == LAST_IDX) begin
              rd_bank      <= other_bank;
              m_axis_tlast <= 1'b0;
              if (full[other_bank]) begin
                m_axis_tdata <= {MAGIC, seq[other_bank]};
                rd_state     <= RD_HDR;
              end else begin
                m_axis_tvalid <= 1'b0;
                rd_state      <= RD_IDLE;
              end
            end else begin
              rd_cnt       <= rd_next;
              m_axis_tdata <= mem[rd_bank][rd_next];
              m_axis_tlast <= (rd_next == LAST_IDX);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
